// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the SEQ Y86 stage sequencer: FSM states, status codes
// and the bit position of each stage enable.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPDATE  = 3'd6,
        ST_HALTED    = 3'd7
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam int NUM_STAGES = 6;
    localparam int STG_FETCH  = 0;
    localparam int STG_DEC    = 1;
    localparam int STG_EXE    = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;
    localparam int STG_PCUP   = 5;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_t s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        case (s)
            ST_FETCH:     oh[STG_FETCH] = 1'b1;
            ST_DECODE:    oh[STG_DEC]   = 1'b1;
            ST_EXECUTE:   oh[STG_EXE]   = 1'b1;
            ST_MEMORY:    oh[STG_MEM]   = 1'b1;
            ST_WRITEBACK: oh[STG_WB]    = 1'b1;
            ST_PCUPDATE:  oh[STG_PCUP]  = 1'b1;
            default:      oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seq_status_reg.sv
// Priority merge of fetch/memory fault sources into the sticky architectural
// status register; halt_req_o flags a new fault that the FSM must act on.
module seq_status_reg
    import seq_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fetch_chk_i,
    input  logic       instr_valid_i,
    input  logic       imem_error_i,
    input  logic       is_halt_i,
    input  logic       mem_err_i,
    input  logic       mem_timeout_i,
    output logic       halt_req_o,
    output logic [1:0] status_o
);

    logic [1:0] status_q;
    logic [1:0] stat_new;

    // Illegal instruction outranks a bad fetch address, which outranks halt.
    always_comb begin
        stat_new = STAT_AOK;
        if (fetch_chk_i) begin
            if (!instr_valid_i)     stat_new = STAT_INS;
            else if (imem_error_i)  stat_new = STAT_ADR;
            else if (is_halt_i)     stat_new = STAT_HLT;
        end else if (mem_err_i || mem_timeout_i) begin
            stat_new = STAT_ADR;
        end
    end

    assign halt_req_o = (status_q == STAT_AOK) && (stat_new != STAT_AOK);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)         status_q <= STAT_AOK;
        else if (halt_req_o) status_q <= stat_new;
    end

    assign status_o = status_q;

endmodule

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle SEQ Y86 controller: one stage per cycle, status-gated strobes,
// cycle and retirement counters.
module seq_stage_sequencer
    import seq_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             is_halt,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic [5:0]       stage_en,
    output logic             regfile_we,
    output logic             dmem_we_en,
    output logic             pc_we,
    output logic [1:0]       status,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int                WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [5:0]        stage_en_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_cnt_q, instr_cnt_q;

    logic fetch_chk, mem_wait, mem_err, mem_tmo, halt_req, aok, active;

    assign fetch_chk = (state_q == ST_FETCH);
    assign mem_wait  = (state_q == ST_MEMORY) && mem_access;
    assign mem_err   = mem_wait && dmem_ready && dmem_error;
    assign mem_tmo   = mem_wait && !dmem_ready && (wait_q == TMO_LAST);

    seq_status_reg u_status (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_chk_i   (fetch_chk),
        .instr_valid_i (instr_valid),
        .imem_error_i  (imem_error),
        .is_halt_i     (is_halt),
        .mem_err_i     (mem_err),
        .mem_timeout_i (mem_tmo),
        .halt_req_o    (halt_req),
        .status_o      (status)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_FETCH;
            ST_FETCH:     state_d = halt_req ? ST_HALTED : ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEMORY;
            ST_MEMORY: begin
                // wait_q counts MEMORY cycles spent without dmem_ready.
                if (halt_req)                     state_d = ST_HALTED;
                else if (!mem_access || dmem_ready) state_d = ST_WRITEBACK;
                else                              wait_d  = wait_q + WAIT_W'(1);
            end
            ST_WRITEBACK: state_d = ST_PCUPDATE;
            ST_PCUPDATE:  state_d = step_mode ? ST_IDLE : ST_FETCH;
            ST_HALTED:    state_d = ST_HALTED;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign active = (state_q != ST_IDLE) && (state_q != ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stage_en_q  <= '0;
            wait_q      <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stage_en_q <= stage_onehot(state_d);
            wait_q     <= wait_d;
            if (active)
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (state_q == ST_PCUPDATE && aok)
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign aok        = (status == STAT_AOK);
    assign regfile_we = aok && (state_q == ST_WRITEBACK);
    assign pc_we      = aok && (state_q == ST_PCUPDATE);
    assign dmem_we_en = aok && mem_wait && (wait_q == '0);

    assign stage_en  = stage_en_q;
    assign running   = active;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Bench for seq_stage_sequencer: scripted instruction streams with a retirement
// scoreboard checked on every pc_we pulse.
module tb_seq_stage_sequencer;
    import seq_ctrl_pkg::*;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n, start, step_mode, instr_valid, imem_error, is_halt;
    logic             mem_access, dmem_ready, dmem_error;
    logic [5:0]       stage_en;
    logic             regfile_we, dmem_we_en, pc_we, running;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int rf_pulses = 0;
    int pc_pulses = 0;
    int model_retired = 0;
    int mc;
    logic [CNT_W-1:0] exp_q[$];

    seq_stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .instr_valid(instr_valid), .imem_error(imem_error), .is_halt(is_halt),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .stage_en(stage_en), .regfile_we(regfile_we), .dmem_we_en(dmem_we_en),
        .pc_we(pc_we), .status(status), .running(running),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Retirement scoreboard and strobe-gating monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (regfile_we) rf_pulses++;
            if (pc_we) begin
                pc_pulses++;
                if (exp_q.size() == 0) chk("retire_unexpected", 64'(pc_pulses), 64'(model_retired));
                else chk("retire_instr_cnt", 64'(instr_cnt), 64'(exp_q.pop_front()));
            end
            if (status != STAT_AOK)
                chk("strobe_gate", {61'd0, regfile_we, pc_we, dmem_we_en}, 64'd0);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; instr_valid = 1'b1;
        imem_error = 1'b0; is_halt = 1'b0; mem_access = 1'b0;
        dmem_ready = 1'b0; dmem_error = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_retired = 0; rf_pulses = 0; pc_pulses = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_stage(input int idx);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (stage_en[idx]) found = 1;
            else @(negedge clk);
        end
        if (!found) chk("wait_stage", 64'(stage_en[idx]), 64'd1);
    endtask

    // Drive one instruction; rdy_delay = -1 means dmem_ready never comes.
    task automatic exec(input bit halt, input bit mem, input int rdy_delay,
                        input bit derr, output int mem_cycles);
        bit done = 0;
        mem_cycles = 0;
        wait_stage(STG_FETCH);
        instr_valid = 1'b1; imem_error = 1'b0; is_halt = halt;
        mem_access = mem; dmem_ready = 1'b0; dmem_error = 1'b0;
        if (!halt) begin
            if (!mem || (rdy_delay >= 0 && !derr)) begin
                exp_q.push_back(CNT_W'(model_retired));
                model_retired++;
            end
            @(negedge clk);
            wait_stage(STG_MEM);
            for (int k = 0; k < 40 && !done; k++) begin
                mem_cycles++;
                chk("dmem_we_en", 64'(dmem_we_en), 64'(mem && mem_cycles == 1));
                dmem_ready = mem && (rdy_delay == mem_cycles - 1);
                dmem_error = derr;
                @(negedge clk);
                if (!stage_en[STG_MEM]) done = 1;
            end
            dmem_ready = 1'b0; dmem_error = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_status", 64'(status), 64'(STAT_AOK));
        chk("rst_stage_en", 64'(stage_en), 64'd0);
        chk("rst_strobes", {61'd0, regfile_we, pc_we, dmem_we_en}, 64'd0);
        chk("rst_counters", {cycle_cnt, instr_cnt}, 64'd0);
        chk("rst_running", 64'(running), 64'd0);

        // Reset asserted for one cycle in the middle of MEMORY
        pulse_start();
        wait_stage(STG_FETCH);
        mem_access = 1'b1;
        @(negedge clk);
        wait_stage(STG_MEM);
        repeat (2) @(negedge clk);
        chk("mid_mem_running", 64'(running), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); model_retired = 0;
        chk("midrst_stage_en", 64'(stage_en), 64'd0);
        chk("midrst_status", 64'(status), 64'(STAT_AOK));
        chk("midrst_counters", {cycle_cnt, instr_cnt}, 64'd0);
        chk("midrst_running", 64'(running), 64'd0);
        @(negedge clk);
        chk("midrst_stays_idle", 64'(stage_en), 64'd0);

        // Three ALU instructions then halt
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            exec(1'b0, 1'b0, 0, 1'b0, mc);
            chk("alu_mem_cycles", 64'(mc), 64'd1);
        end
        exec(1'b1, 1'b0, 0, 1'b0, mc);
        repeat (3) @(negedge clk);
        chk("hlt_status", 64'(status), 64'(STAT_HLT));
        chk("hlt_instr_cnt", 64'(instr_cnt), 64'd3);
        chk("hlt_cycle_cnt", 64'(cycle_cnt), 64'd19);
        chk("hlt_pc_pulses", 64'(pc_pulses), 64'd3);
        chk("hlt_rf_pulses", 64'(rf_pulses), 64'd3);
        chk("hlt_stage_en", 64'(stage_en), 64'd0);
        chk("hlt_running", 64'(running), 64'd0);

        // INS outranks ADR at fetch
        do_reset();
        pulse_start();
        wait_stage(STG_FETCH);
        instr_valid = 1'b0; imem_error = 1'b1;
        repeat (4) @(negedge clk);
        chk("ins_status", 64'(status), 64'(STAT_INS));
        chk("ins_rf_pc", 64'(rf_pulses + pc_pulses), 64'd0);
        chk("ins_instr_cnt", 64'(instr_cnt), 64'd0);
        chk("ins_cycle_cnt", 64'(cycle_cnt), 64'd1);

        // Memory op with dmem_ready delayed 4 cycles
        do_reset();
        pulse_start();
        exec(1'b0, 1'b1, 4, 1'b0, mc);
        chk("memdly_cycles", 64'(mc), 64'd5);
        exec(1'b1, 1'b0, 0, 1'b0, mc);
        repeat (3) @(negedge clk);
        chk("memdly_instr_cnt", 64'(instr_cnt), 64'd1);
        chk("memdly_cycle_cnt", 64'(cycle_cnt), 64'd11);
        chk("memdly_status", 64'(status), 64'(STAT_HLT));

        // Data-memory error: sticky ADR
        do_reset();
        pulse_start();
        exec(1'b0, 1'b1, 0, 1'b1, mc);
        repeat (2) @(negedge clk);
        chk("derr_status", 64'(status), 64'(STAT_ADR));
        chk("derr_running", 64'(running), 64'd0);
        pulse_start();
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        instr_valid = 1'b1;
        chk("derr_sticky", 64'(status), 64'(STAT_ADR));
        chk("derr_stage_en", 64'(stage_en), 64'd0);
        chk("derr_instr_cnt", 64'(instr_cnt), 64'd0);
        chk("derr_rf_pulses", 64'(rf_pulses), 64'd0);

        // Step mode, resume, then dmem timeout
        do_reset();
        step_mode = 1'b1;
        pulse_start();
        exec(1'b0, 1'b0, 0, 1'b0, mc);
        repeat (3) @(negedge clk);
        chk("step1_running", 64'(running), 64'd0);
        chk("step1_stage_en", 64'(stage_en), 64'd0);
        chk("step1_instr_cnt", 64'(instr_cnt), 64'd1);
        pulse_start();
        exec(1'b0, 1'b0, 0, 1'b0, mc);
        repeat (3) @(negedge clk);
        chk("step2_instr_cnt", 64'(instr_cnt), 64'd2);
        chk("step2_running", 64'(running), 64'd0);
        pulse_start();
        exec(1'b0, 1'b1, -1, 1'b0, mc);
        chk("tmo_mem_cycles", 64'(mc), 64'(MEM_TIMEOUT));
        repeat (2) @(negedge clk);
        chk("tmo_status", 64'(status), 64'(STAT_ADR));
        chk("tmo_instr_cnt", 64'(instr_cnt), 64'd2);
        chk("tmo_running", 64'(running), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
